shift_seq_reg: RTL

//  Parametrised multi-mode shift register with an automatic shift sequencer.

---
 rtl/shift_seq_reg.sv | 118 +++++++++++
 1 files changed

// File: rtl/shift_seq_reg.sv
// Multi-mode shift register with a counted shift/rotate sequencer.
// Supports parallel load, manual single-step shifts, and counted sequences that report busy/done.
module shift_seq_reg #(
  parameter int P_NBITS       = 8,
  parameter bit P_RESET_VALUE = 1'b0,
  parameter int P_CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [P_NBITS-1:0] load,
  input  logic [2:0]         mode,
  input  logic               d_in,
  input  logic               en,
  input  logic               start,
  input  logic [P_CNT_W-1:0] count,
  output logic [P_NBITS-1:0] q,
  output logic               s_out,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] MODE_SHL = 3'd0;
  localparam logic [2:0] MODE_SHR = 3'd1;
  localparam logic [2:0] MODE_ROL = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ASR = 3'd4;
  localparam logic [2:0] MODE_LSL = 3'd5;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic [P_NBITS-1:0] q_q, q_d;
  logic               s_out_q, s_out_d;
  logic               state_q, state_d;
  logic [P_CNT_W-1:0] rem_q, rem_d;
  logic [2:0]         mode_q, mode_d;
  logic               done_q, done_d;

  // Returns {bit shifted out, new register value}.
  // Reserved modes return the current s_out and q unchanged.
  function automatic logic [P_NBITS:0] shift_fn(
    input logic [2:0]         m,
    input logic [P_NBITS-1:0] v,
    input logic               din,
    input logic               so
  );
    logic [P_NBITS:0] r;
    case (m)
      MODE_SHL: r = {v[P_NBITS-1], v[P_NBITS-2:0], din};
      MODE_SHR: r = {v[0], din, v[P_NBITS-1:1]};
      MODE_ROL: r = {v[P_NBITS-1], v[P_NBITS-2:0], v[P_NBITS-1]};
      MODE_ROR: r = {v[0], v[0], v[P_NBITS-1:1]};
      MODE_ASR: r = {v[0], v[P_NBITS-1], v[P_NBITS-1:1]};
      MODE_LSL: r = {v[P_NBITS-1], v[P_NBITS-2:0], 1'b0};
      default:  r = {so, v};
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    q_d     = q_q;
    s_out_d = s_out_q;
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    if (load_en) begin
      // A load aborts a running sequence without signalling completion.
      q_d     = load;
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      {s_out_d, q_d} = shift_fn(mode_q, q_q, d_in, s_out_q);
      rem_d          = rem_q - P_CNT_W'(1);
      if (rem_q == P_CNT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      if (count != '0) begin
        mode_d  = mode;
        rem_d   = count;
        state_d = ST_RUN;
      end else begin
        done_d = 1'b1;
      end
    end else if (en) begin
      {s_out_d, q_d} = shift_fn(mode, q_q, d_in, s_out_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= {P_NBITS{P_RESET_VALUE}};
      s_out_q <= 1'b0;
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign q     = q_q;
  assign s_out = s_out_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;

endmodule
